fwd_hazard_unit: RTL and testbench



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/fwd_src_match.sv | 35 +++
 rtl/fwd_hazard_unit.sv | 147 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for forwarding/hazard logic
//
// Purpose : scoreboard entry type, select encoding and the register address
//           width shared with the register file and decode.
// Ports   : none (package).
package pipe_pkg;

    // Register address width used across the pipeline.
    localparam int DEF_ADDR_W = 3;

    // Select value that routes an operand from the register file.
    localparam int SEL_REGFILE = 0;

    // One tracked producer: does it write a register, which one, is it a load.
    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  is_load;
    } sb_entry_t;

endpackage

// File: rtl/fwd_src_match.sv
// rtl/fwd_src_match.sv - youngest-match priority encoder for one source operand
//
// Purpose : picks the youngest scoreboard slot writing this source register
//           and flags a load-use hazard when that slot's data is not ready.
// Ports   : src_addr_i  source register address
//           sb_i        scoreboard, element k-1 holds slot k (slot 1 youngest)
//           sel_o       0 = register file, k = bypass bus k
//           hazard_o    youngest match is a load still inside the load latency
module fwd_src_match
    import pipe_pkg::*;
#(
    parameter int ADDR_W   = pipe_pkg::DEF_ADDR_W,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic [ADDR_W-1:0]        src_addr_i,
    input  sb_entry_t [DEPTH-1:0]    sb_i,
    output logic [SEL_W-1:0]         sel_o,
    output logic                     hazard_o
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel_o    = SEL_W'(SEL_REGFILE);
        hazard_o = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if ((src_addr_i != '0) && sb_i[k-1].valid && (sb_i[k-1].addr == src_addr_i)) begin
                sel_o    = SEL_W'(k);
                hazard_o = sb_i[k-1].is_load && (k <= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - parametrised forwarding select and load-use stall unit
//
// Purpose : tracks the last DEPTH register writers in a shift-register
//           scoreboard, selects the youngest bypass bus per source operand,
//           stalls issue on load-use and registers selects into EX.
// Ports   : clk_i, rst_i (async active-high)
//           issue_valid_i / issue_ready_o   issue handshake
//           src_addr_i    NUM_SRC packed source addresses
//           dst_addr_i, dst_we_i, dst_memread_i   producer description
//           flush_i       squash all tracking and any simultaneous issue
//           sel_o, sel_valid_o   registered per-source selects for EX
//           stall_o       load-use stall
//           stall_cnt_o, fwd_cnt_o   saturating statistics, present only
//                         when FWD_HAZARD_STATS_EN is defined
// The scoreboard entry address field uses the shared package width, so
// ADDR_W is expected to equal pipe_pkg::DEF_ADDR_W.
module fwd_hazard_unit #(
    parameter int ADDR_W   = pipe_pkg::DEF_ADDR_W,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [NUM_SRC*ADDR_W-1:0]  src_addr_i,
    input  logic [ADDR_W-1:0]          dst_addr_i,
    input  logic                       dst_we_i,
    input  logic                       dst_memread_i,
    input  logic                       flush_i,
    output logic [NUM_SRC*SEL_W-1:0]   sel_o,
    output logic                       sel_valid_o,
    output logic                       stall_o
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                fwd_cnt_o
`endif
);
    import pipe_pkg::*;

    sb_entry_t [DEPTH-1:0]      sb_q, sb_d;
    logic [NUM_SRC*SEL_W-1:0]   sel_q, sel_d;
    logic                       sel_valid_q, sel_valid_d;

    logic [NUM_SRC*SEL_W-1:0]   sel_comb;
    logic [NUM_SRC-1:0]         hazard;
    logic                       accept;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        fwd_src_match #(
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SEL_W    (SEL_W)
        ) u_match (
            .src_addr_i (src_addr_i[n*ADDR_W +: ADDR_W]),
            .sb_i       (sb_q),
            .sel_o      (sel_comb[n*SEL_W +: SEL_W]),
            .hazard_o   (hazard[n])
        );
    end

    assign stall_o       = issue_valid_i & (|hazard) & ~flush_i;
    assign issue_ready_o = ~stall_o;
    assign accept        = issue_valid_i & issue_ready_o & ~flush_i;

    // A stalled or idle cycle shifts in an invalid entry, so a pending load
    // ages one slot per cycle and the stall releases without a counter.
    always_comb begin
        sb_d        = sb_q;
        sel_d       = '0;
        sel_valid_d = 1'b0;
        if (flush_i) begin
            sb_d = '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0].valid   = accept & dst_we_i & (dst_addr_i != '0);
            sb_d[0].addr    = dst_addr_i;
            sb_d[0].is_load = dst_memread_i;
            sel_d           = accept ? sel_comb : '0;
            sel_valid_d     = accept;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_q        <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            sb_q        <= sb_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    assign sel_o       = sel_q;
    assign sel_valid_o = sel_valid_q;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] n_fwd;
    logic [32:0] fwd_sum;

    always_comb begin
        n_fwd = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            if (sel_comb[n*SEL_W +: SEL_W] != '0) begin
                n_fwd = n_fwd + 32'd1;
            end
        end
    end

    assign fwd_sum = {1'b0, fwd_cnt_q} + {1'b0, n_fwd};

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (accept) begin
            fwd_cnt_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Default configuration: DEPTH 2, LOAD_LAT 1, SEL_W 2
    logic       iv, ready, flush, we, ld, stall, sel_valid;
    logic [5:0] src;
    logic [2:0] dst;
    logic [3:0] sel;

    // Sweep configuration: DEPTH 4, LOAD_LAT 2, SEL_W 3
    logic       iv4, ready4, flush4, we4, ld4, stall4, sel_valid4;
    logic [5:0] src4;
    logic [2:0] dst4;
    logic [5:0] sel4;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt, stall_cnt4, fwd_cnt4;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (iv),
        .issue_ready_o (ready),
        .src_addr_i    (src),
        .dst_addr_i    (dst),
        .dst_we_i      (we),
        .dst_memread_i (ld),
        .flush_i       (flush),
        .sel_o         (sel),
        .sel_valid_o   (sel_valid),
        .stall_o       (stall)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stall_cnt_o   (stall_cnt),
        .fwd_cnt_o     (fwd_cnt)
`endif
    );

    fwd_hazard_unit #(.DEPTH(4), .LOAD_LAT(2)) u_dut4 (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (iv4),
        .issue_ready_o (ready4),
        .src_addr_i    (src4),
        .dst_addr_i    (dst4),
        .dst_we_i      (we4),
        .dst_memread_i (ld4),
        .flush_i       (flush4),
        .sel_o         (sel4),
        .sel_valid_o   (sel_valid4),
        .stall_o       (stall4)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stall_cnt_o   (stall_cnt4),
        .fwd_cnt_o     (fwd_cnt4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // v, src0, src1, dst, we, ld
    task automatic issue(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [2:0] d, input logic w, input logic l);
        iv = v; src = {s1, s0}; dst = d; we = w; ld = l;
    endtask

    task automatic issue4(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                          input logic [2:0] d, input logic w, input logic l);
        iv4 = v; src4 = {s1, s0}; dst4 = d; we4 = w; ld4 = l;
    endtask

    initial begin
        flush = 1'b0; flush4 = 1'b0;
        issue(0, 0, 0, 0, 0, 0);
        issue4(0, 0, 0, 0, 0, 0);
        repeat (2) step();
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_ready", {31'd0, ready}, 1);
        chk("rst_sel", {28'd0, sel}, 0);
        chk("rst_selv", {31'd0, sel_valid}, 0);
        chk("rst_sel4", {26'd0, sel4}, 0);
        rst = 1'b0;
        step();

        // Forward from bus 1: write r3, then read r3/r5
        issue(1, 0, 0, 3, 1, 0);
        step();
        chk("alu_selv", {31'd0, sel_valid}, 1);
        chk("alu_sel", {28'd0, sel}, 0);
        issue(1, 3, 5, 0, 0, 0);
        #1 chk("fwd1_stall", {31'd0, stall}, 0);
        step();
        chk("fwd1_sel", {28'd0, sel}, 4'b00_01);
        chk("fwd1_selv", {31'd0, sel_valid}, 1);
        issue(0, 0, 0, 0, 0, 0);
        repeat (2) step();
        chk("idle_selv", {31'd0, sel_valid}, 0);

        // Youngest wins: two writes of r2, read r2 on both sources
        issue(1, 0, 0, 2, 1, 0); step();
        issue(1, 0, 0, 2, 1, 0); step();
        issue(1, 2, 2, 0, 0, 0);
        #1 chk("young_stall", {31'd0, stall}, 0);
        step();
        chk("young_sel", {28'd0, sel}, 4'b01_01);
        issue(0, 0, 0, 0, 0, 0); repeat (2) step();

        // Load-use: load r4 then read r4, one bubble then bus 2
        issue(1, 0, 0, 4, 1, 1); step();
        issue(1, 4, 0, 0, 0, 0);
        #1 chk("lu_stall", {31'd0, stall}, 1);
        chk("lu_ready", {31'd0, ready}, 0);
        step();
        chk("lu_bub_selv", {31'd0, sel_valid}, 0);
        chk("lu_bub_sel", {28'd0, sel}, 0);
        #1 chk("lu_release", {31'd0, stall}, 0);
        step();
        chk("lu_sel", {28'd0, sel}, 4'b00_10);
        chk("lu_selv", {31'd0, sel_valid}, 1);
        issue(0, 0, 0, 0, 0, 0); repeat (2) step();

        // r0: a load to r0 then a read of r0 neither forwards nor stalls
        issue(1, 0, 0, 0, 1, 1); step();
        issue(1, 0, 0, 0, 0, 0);
        #1 chk("r0_stall", {31'd0, stall}, 0);
        step();
        chk("r0_sel", {28'd0, sel}, 0);
        chk("r0_selv", {31'd0, sel_valid}, 1);
        issue(0, 0, 0, 0, 0, 0); repeat (2) step();

        // Flush: load r6, then flush with a read of r6
        issue(1, 0, 0, 6, 1, 1); step();
        issue(1, 6, 0, 0, 0, 0); flush = 1'b1;
        #1 chk("fl_stall", {31'd0, stall}, 0);
        step();
        chk("fl_selv", {31'd0, sel_valid}, 0);
        flush = 1'b0;
        #1 chk("fl_after_stall", {31'd0, stall}, 0);
        step();
        chk("fl_after_sel", {28'd0, sel}, 0);
        chk("fl_after_selv", {31'd0, sel_valid}, 1);
        issue(0, 0, 0, 0, 0, 0); repeat (2) step();

        // Reset mid-stall: write r5, load r4 using r5, read r4
        issue(1, 0, 0, 5, 1, 0); step();
        issue(1, 5, 0, 4, 1, 1); step();
        chk("pre_rst_sel", {28'd0, sel}, 4'b00_01);
        issue(1, 4, 0, 0, 0, 0);
        #1 chk("pre_rst_stall", {31'd0, stall}, 1);
        rst = 1'b1;
        #1 chk("mid_rst_stall", {31'd0, stall}, 0);
        chk("mid_rst_sel", {28'd0, sel}, 0);
        chk("mid_rst_selv", {31'd0, sel_valid}, 0);
        step();
        rst = 1'b0;
        #1 chk("post_rst_stall", {31'd0, stall}, 0);
        step();
        chk("post_rst_sel", {28'd0, sel}, 0);
        chk("post_rst_selv", {31'd0, sel_valid}, 1);
        issue(0, 0, 0, 0, 0, 0); step();

        // Sweep DEPTH 4, LOAD_LAT 2: load r1, read r1, two stalls, bus 3
        issue4(1, 0, 0, 1, 1, 1); step();
        issue4(1, 1, 0, 0, 0, 0);
        #1 chk("d4_stall1", {31'd0, stall4}, 1);
        step();
        chk("d4_bub_selv", {31'd0, sel_valid4}, 0);
        #1 chk("d4_stall2", {31'd0, stall4}, 1);
        step();
        #1 chk("d4_release", {31'd0, stall4}, 0);
        step();
        chk("d4_sel", {26'd0, sel4}, 6'b000_011);
        chk("d4_selv", {31'd0, sel_valid4}, 1);
        issue4(0, 0, 0, 0, 0, 0); step();
`ifdef FWD_HAZARD_STATS_EN
        chk("d4_stall_cnt", stall_cnt4, 2);
        chk("d4_fwd_cnt", fwd_cnt4, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
